// File: rtl/binaris_modulo.sv
// Parametrised up/down modulo counter with programmable step, parallel load,
// wrap or saturate at the modulus, terminal-count pulse and sticky overflow.
module binaris_modulo #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned MAXVAL = 2**WIDTH - 1,
   parameter bit          SAT    = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] lep,
   input  logic             elore,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   // One extra bit so MAXVAL+1 == 2**WIDTH and q+s never overflow.
   localparam logic [WIDTH:0]   MAXV = (WIDTH+1)'(MAXVAL);
   localparam logic [WIDTH:0]   MODV = MAXV + (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] MAXQ = WIDTH'(MAXVAL);

   logic [WIDTH:0]   q_ext;
   logic [WIDTH:0]   d_ext;
   logic [WIDTH:0]   lep_ext;
   logic [WIDTH:0]   s;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] q_nxt;
   logic             tc_nxt;

   assign q_ext   = {1'b0, q};
   assign d_ext   = {1'b0, d};
   assign lep_ext = {1'b0, lep};

   always_comb begin
      q_nxt  = q;
      tc_nxt = 1'b0;
      // Clamping the step keeps any wrap within a single modulus correction.
      s      = (lep_ext > MAXV) ? MAXV : lep_ext;
      sum    = q_ext + s;
      if (load) begin
         q_nxt = (d_ext > MAXV) ? MAXQ : d;
      end else if (en) begin
         if (elore) begin
            if (sum > MAXV) begin
               tc_nxt = 1'b1;
               q_nxt  = SAT ? MAXQ : WIDTH'(sum - MODV);
            end else begin
               q_nxt  = sum[WIDTH-1:0];
            end
         end else begin
            if (s > q_ext) begin
               tc_nxt = 1'b1;
               q_nxt  = SAT ? '0 : WIDTH'(q_ext + MODV - s);
            end else begin
               q_nxt  = WIDTH'(q_ext - s);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q   <= '0;
         tc  <= 1'b0;
         ovf <= 1'b0;
      end else begin
         q   <= q_nxt;
         tc  <= tc_nxt;
         ovf <= tc_nxt | (ovf & ~clr_ovf);
      end
   end

endmodule

// File: tb/tb_binaris_modulo.sv
// Scoreboard bench for binaris_modulo: three configurations share stimulus,
// expected state is pushed when driving and popped after each edge.
module tb_binaris_modulo;

   logic       clk = 1'b0;
   logic       reset, en, load, elore, clr_ovf;
   logic [7:0] d, lep;
   logic [7:0] q_d, q_w, q_s;
   logic       tc_d, tc_w, tc_s, ovf_d, ovf_w, ovf_s;

   int nerr = 0;
   int nchk = 0;

   int mq[3];
   int mtc[3];
   int movf[3];
   int maxv[3] = '{255, 9, 9};
   bit satm[3] = '{1'b0, 1'b0, 1'b1};
   int exp_q[$];

   always #5 clk = ~clk;

   binaris_modulo u_def (
      .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .lep(lep),
      .elore(elore), .clr_ovf(clr_ovf), .q(q_d), .tc(tc_d), .ovf(ovf_d));

   binaris_modulo #(.WIDTH(8), .MAXVAL(9), .SAT(1'b0)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .lep(lep),
      .elore(elore), .clr_ovf(clr_ovf), .q(q_w), .tc(tc_w), .ovf(ovf_w));

   binaris_modulo #(.WIDTH(8), .MAXVAL(9), .SAT(1'b1)) u_sat (
      .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .lep(lep),
      .elore(elore), .clr_ovf(clr_ovf), .q(q_s), .tc(tc_s), .ovf(ovf_s));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] dut_q(input int k);
      case (k)
         0:       return {24'b0, q_d};
         1:       return {24'b0, q_w};
         default: return {24'b0, q_s};
      endcase
   endfunction

   function automatic logic [31:0] dut_tc(input int k);
      case (k)
         0:       return {31'b0, tc_d};
         1:       return {31'b0, tc_w};
         default: return {31'b0, tc_s};
      endcase
   endfunction

   function automatic logic [31:0] dut_ovf(input int k);
      case (k)
         0:       return {31'b0, ovf_d};
         1:       return {31'b0, ovf_w};
         default: return {31'b0, ovf_s};
      endcase
   endfunction

   // Behavioural reference: modular arithmetic on plain integers.
   task automatic model(input bit r, ld, e, dir, co, input int dv, lv);
      for (int k = 0; k < 3; k++) begin
         int m, s, t;
         m = maxv[k];
         if (r) begin
            mq[k] = 0; mtc[k] = 0; movf[k] = 0;
         end else begin
            if (ld) begin
               mq[k]  = (dv > m) ? m : dv;
               mtc[k] = 0;
            end else if (e) begin
               s = (lv > m) ? m : lv;
               if (dir) begin
                  t = mq[k] + s;
                  mtc[k] = (t > m) ? 1 : 0;
                  mq[k]  = (t > m && satm[k]) ? m : t % (m + 1);
               end else begin
                  t = mq[k] - s;
                  mtc[k] = (t < 0) ? 1 : 0;
                  mq[k]  = (t < 0 && satm[k]) ? 0 : (t + m + 1) % (m + 1);
               end
            end else begin
               mtc[k] = 0;
            end
            movf[k] = (mtc[k] != 0 || (movf[k] != 0 && !co)) ? 1 : 0;
         end
         exp_q.push_back(mq[k]);
         exp_q.push_back(mtc[k]);
         exp_q.push_back(movf[k]);
      end
   endtask

   task automatic cyc(input bit r, ld, e, dir, co, input int dv, lv, input bit glitch = 1'b0);
      reset = r; load = ld; en = e; elore = dir; clr_ovf = co;
      d = 8'(dv); lep = 8'(lv);
      model(r, ld, e, dir, co, dv, lv);
      if (glitch) begin
         #2 reset = 1'b1;
         #2 reset = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("q%0d", k),   dut_q(k),   32'(exp_q.pop_front()));
         check($sformatf("tc%0d", k),  dut_tc(k),  32'(exp_q.pop_front()));
         check($sformatf("ovf%0d", k), dut_ovf(k), 32'(exp_q.pop_front()));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; load = 1'b0; en = 1'b0; elore = 1'b1; clr_ovf = 1'b0;
      d = '0; lep = '0;
      cyc(1, 0, 0, 1, 0, 0, 0);
      check("rst_q", q_d, 0);
      check("rst_tc", tc_w, 0);
      check("rst_ovf", ovf_s, 0);

      // Full-range wrap on the default instance
      for (int i = 0; i < 256; i++) cyc(0, 0, 1, 1, 0, 0, 1);
      check("wrap256_q", q_d, 0);
      check("wrap256_tc", tc_d, 1);
      check("wrap256_ovf", ovf_d, 1);
      cyc(0, 0, 1, 1, 0, 0, 1);
      check("after_wrap_q", q_d, 1);
      check("after_wrap_tc", tc_d, 0);
      check("after_wrap_ovf", ovf_d, 1);

      // Modulus 10, wrap and saturate
      cyc(1, 0, 0, 1, 0, 0, 0);
      cyc(0, 1, 0, 1, 0, 7, 0);
      cyc(0, 0, 1, 1, 0, 0, 5);
      check("w_up5_q", q_w, 2);  check("w_up5_tc", tc_w, 1);
      cyc(0, 0, 1, 0, 0, 0, 5);
      check("w_dn5_q", q_w, 7);  check("w_dn5_tc", tc_w, 1);
      cyc(0, 0, 1, 0, 0, 0, 20);
      check("w_dn20_q", q_w, 8); check("w_dn20_tc", tc_w, 1);

      cyc(0, 1, 0, 1, 0, 8, 0);
      cyc(0, 0, 1, 1, 0, 0, 3);
      check("s_up3_q", q_s, 9);  check("s_up3_tc", tc_s, 1);
      cyc(0, 0, 1, 1, 0, 0, 3);
      check("s_up3b_q", q_s, 9); check("s_up3b_tc", tc_s, 1);
      cyc(0, 1, 0, 0, 0, 1, 0);
      cyc(0, 0, 1, 0, 0, 0, 4);
      check("s_dn4_q", q_s, 0);  check("s_dn4_tc", tc_s, 1);
      cyc(0, 0, 1, 0, 0, 0, 0);
      check("s_dn0_q", q_s, 0);  check("s_dn0_tc", tc_s, 0);

      cyc(0, 1, 0, 1, 0, 12, 0);
      check("ld12_q", q_w, 9);
      cyc(0, 1, 1, 1, 0, 3, 1);
      check("ld_en_q", q_w, 3);  check("ld_en_tc", tc_w, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0, 1);
      check("hold_q", q_w, 3);

      // Sticky overflow: set beats clear, then clear alone
      cyc(1, 0, 0, 1, 0, 0, 0);
      cyc(0, 1, 0, 1, 0, 9, 0);
      cyc(0, 0, 1, 1, 1, 0, 1);
      check("ovf_set_wins", ovf_w, 1);
      cyc(0, 0, 0, 1, 1, 0, 0);
      check("ovf_clr", ovf_w, 0);

      // Reset overrides load/en mid-count
      cyc(0, 1, 0, 1, 0, 8, 0);
      cyc(0, 0, 1, 1, 0, 0, 5);
      cyc(1, 1, 1, 1, 0, 5, 1);
      check("rst_mid_q", q_w, 0); check("rst_mid_tc", tc_w, 0); check("rst_mid_ovf", ovf_w, 0);

      // Reset pulse between edges is ignored
      cyc(0, 0, 1, 1, 0, 0, 1);
      cyc(0, 0, 1, 1, 0, 0, 1, 1'b1);
      check("glitch_q", q_w, 2);

      // Random mixed traffic
      for (int i = 0; i < 200; i++)
         cyc(0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
             ($urandom_range(0, 4) == 0), $urandom_range(0, 255), $urandom_range(0, 12));

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
